// File: rtl/ram_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ram_reader                                                |
// | Function : Sweeps len consecutive RAM addresses from base (wrapping) |
// |            and streams each word out on a valid/ready/last interface.|
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ram_reader #(
  parameter int DATASIZE = 12,
  parameter int ADDRSIZE = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDRSIZE-1:0] base,
  input  logic [ADDRSIZE:0]   len,
  output logic [ADDRSIZE-1:0] ram_addr,
  output logic                ram_enw,
  input  logic [DATASIZE-1:0] ram_datao,
  output logic [DATASIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2
  } state_t;

  // Full buffer depth; len is clamped to this so one readout never repeats a word.
  localparam logic [ADDRSIZE:0] c_depth = {1'b1, {ADDRSIZE{1'b0}}};

  state_t                r_state;
  state_t                w_state;
  logic [ADDRSIZE:0]     r_cnt;
  logic [ADDRSIZE:0]     w_cnt;
  logic [ADDRSIZE-1:0]   w_addr;
  logic [DATASIZE-1:0]   w_data;
  logic                  w_valid;
  logic                  w_last;
  logic                  w_done;
  logic                  w_capture;
  logic                  w_xfer;

  // The RAM write port belongs to the capture side; this block only reads.
  assign ram_enw = 1'b0;
  assign busy    = (r_state != S_IDLE);
  assign w_xfer  = out_valid && out_ready;

  // State register plus all registered outputs and the remaining-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      ram_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      ram_addr  <= w_addr;
      out_data  <= w_data;
      out_valid <= w_valid;
      out_last  <= w_last;
      done      <= w_done;
    end
  end

  // Next-state and next-output logic; abort overrides everything, including a
  // handshake completing in the same cycle (that word is delivered, no done).
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_addr    = ram_addr;
    w_data    = out_data;
    w_valid   = out_valid;
    w_last    = out_last;
    w_done    = 1'b0;
    w_capture = 1'b0;

    if (abort) begin
      w_state = S_IDLE;
      w_valid = 1'b0;
      w_last  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (len == '0) begin
              w_done = 1'b1;
            end else begin
              w_cnt   = (len > c_depth) ? c_depth : len;
              w_addr  = base;
              w_state = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          w_capture = 1'b1;
          w_state   = S_SEND;
        end
        S_SEND: begin
          if (w_xfer) begin
            if (out_last) begin
              w_valid = 1'b0;
              w_last  = 1'b0;
              w_done  = 1'b1;
              w_state = S_IDLE;
            end else begin
              w_capture = 1'b1;
            end
          end
        end
        default: w_state = S_IDLE;
      endcase
    end

    // Read data is combinational, so the word at ram_addr is captured in the
    // same cycle the address is presented, then the address moves on.
    if (w_capture) begin
      w_data  = ram_datao;
      w_valid = 1'b1;
      w_last  = (r_cnt == (ADDRSIZE+1)'(1));
      w_addr  = ram_addr + ADDRSIZE'(1);
      w_cnt   = r_cnt - (ADDRSIZE+1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: doc/ram_reader.md
# ram_reader

Read-side sequencer for the sample RAM (single port, combinational read, DATASIZE-bit words). On a start pulse it sweeps `len` consecutive addresses from `base`, wrapping modulo 2^ADDRSIZE. Each word it reads is presented on a valid/ready stream with a last flag. It sits between the capture RAM and the readout link (SPI/FIFO packer). External arbitration uses `busy` to hand the RAM address port to this block.

## Interface
- DATASIZE, 12, RAM word width
- ADDRSIZE, 7, RAM address width; the buffer holds 2^ADDRSIZE words
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a readout; sampled only in IDLE
- abort  in  1  synchronous cancel, effective in any state
- base  in  ADDRSIZE  first address to read; sampled with `start`
- len  in  ADDRSIZE+1  number of words to read; sampled with `start`; values above 2^ADDRSIZE clamp to 2^ADDRSIZE
- ram_addr  out  ADDRSIZE  address to RAM port
- ram_enw  out  1  RAM write enable, constant 0
- ram_datao  in  DATASIZE  RAM combinational read data
- out_data  out  DATASIZE  stream word, registered
- out_valid  out  1  stream word valid
- out_ready  in  1  downstream accept
- out_last  out  1  high with the final word of a readout
- busy  out  1  high in LOAD and SEND
- done  out  1  one-cycle pulse at normal completion

## Operation
- The state machine has three states: IDLE, LOAD, SEND.
- Reset forces IDLE. All outputs reset to 0: ram_addr, out_data, out_valid, out_last, busy, done.
- A beat transfers when out_valid && out_ready.
- IDLE with start=1, abort=0, len≠0:
  - latch cnt=min(len, 2^ADDRSIZE)
  - set ram_addr<=base
  - go to LOAD
- IDLE with start=1 and len=0: stay in IDLE, pulse done next cycle, send no beats.
- LOAD:
  - out_data<=ram_datao
  - out_valid<=1
  - out_last<=(cnt==1)
  - ram_addr<=ram_addr+1 (wraps 2^ADDRSIZE-1 -> 0)
  - cnt<=cnt-1
  - go to SEND
- SEND with no transfer: hold out_data, out_valid, out_last and ram_addr unchanged (no data loss under backpressure).
- SEND with a transfer and out_last=1: out_valid<=0, out_last<=0, done<=1, go to IDLE.
- SEND with a transfer and out_last=0: load the next word the same way LOAD does (capture, increment, decrement). out_valid stays 1, giving one word per cycle.
- abort=1 in any state: next cycle is IDLE with out_valid=0, out_last=0, busy=0, and no done pulse. Abort has priority over start and over a simultaneous transfer. A word whose handshake coincides with abort counts as delivered, but out_last/done are suppressed.
- start while busy is ignored. base and len changes mid-readout have no effect.
- ram_enw is always 0. Write access belongs to the capture side while busy=0.
- Address arithmetic is ADDRSIZE bits with natural overflow. cnt is ADDRSIZE+1 bits, so len=2^ADDRSIZE reads every word exactly once.

## Timing
- Edge k samples start. LOAD at k+1. First out_valid=1 at k+2, with out_data=mem[base].
- With out_ready held high, words appear on consecutive cycles. N words occupy cycles k+2 … k+N+1.
- done pulses in the cycle after the last transfer. busy falls in that same cycle.
- A new start is accepted in the cycle done is high. Back-to-back readout gap: 2 idle cycles on the stream.
- ram_datao is sampled in the same cycle ram_addr is driven. RAM read is combinational; there is no extra wait state.
- Async rst_n assertion mid-readout clears all outputs immediately. Deassertion returns to IDLE.

## Test plan
- Load RAM with mem[i]=i+0x100. Issue start with base=0, len=4, ready high -> words 0x100…0x103 on cycles k+2…k+5, out_last only on 0x103, done at k+6.
- Issue start with base=126, len=4 (ADDRSIZE=7) -> words from addresses 126, 127, 0, 1 in that order, with no gap at the wrap.
- Toggle out_ready in a 1-0-0-1 pattern with len=3 -> each word held stable while ready=0, exactly 3 transfers, no duplicates or drops.
- Issue start with len=200 (clamps to 128) and base=5 -> exactly 128 words, last from address 4, done asserted once.
- Assert abort with start while IDLE -> nothing happens. Assert abort after the 2nd transfer of len=8 -> out_valid=0 next cycle, no done, busy=0.
- Issue start with len=0 -> done pulse one cycle later, out_valid never high. Assert rst_n low mid-readout -> all outputs 0 immediately.
